// File: rtl/ones_counter_oh_if.sv
// Handshake/result bundle for ones_counter_oh.
// The abort wire exists only when ONES_CNT_ABORT_EN is defined.
interface ones_counter_oh_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] data_in;
`ifdef ONES_CNT_ABORT_EN
    logic             abort;
`endif
    logic             rdy;
    logic             done;
    logic [CW-1:0]    count;
    logic             load_regs;
    logic             shift;
    logic             incr_r2;
    logic [3:0]       state;

`ifdef ONES_CNT_ABORT_EN
    modport master (output start, data_in, abort,
                    input  rdy, done, count, load_regs, shift, incr_r2, state);
    modport slave  (input  start, data_in, abort,
                    output rdy, done, count, load_regs, shift, incr_r2, state);
`else
    modport master (output start, data_in,
                    input  rdy, done, count, load_regs, shift, incr_r2, state);
    modport slave  (input  start, data_in,
                    output rdy, done, count, load_regs, shift, incr_r2, state);
`endif
endinterface

// File: rtl/ones_counter_oh.sv
// Shift-and-count ones counter with a one-hot controller (S_idle/S_1/S_2/S_3).
// Optional abort input enabled by defining ONES_CNT_ABORT_EN.
module ones_counter_oh #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    ones_counter_oh_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_1    = 4'b0010,
        S_2    = 4'b0100,
        S_3    = 4'b1000
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [CW-1:0]    r2_q, r2_d;
    logic             e_q, e_d;
    logic             done_q, done_d;
    logic             load_regs, shift, incr_r2;
    logic             abort_w;

`ifdef ONES_CNT_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        e_d       = e_q;
        done_d    = 1'b0;
        load_regs = 1'b0;
        shift     = 1'b0;
        incr_r2   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load_regs = 1'b1;
                    r1_d      = bus.data_in;
                    r2_d      = '0;
                    e_d       = 1'b0;
                    state_d   = S_1;
                end
            end
            S_1: begin
                if (r1_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_2;
                end
            end
            S_2: begin
                shift   = 1'b1;
                r1_d    = r1_q >> 1;
                e_d     = r1_q[0];
                state_d = S_3;
            end
            S_3: begin
                if (e_q) begin
                    incr_r2 = 1'b1;
                    r2_d    = r2_q + CW'(1);
                    state_d = S_1;
                end else begin
                    state_d = S_2;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides only the transition; this cycle's datapath update still lands.
        if (abort_w && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r1_q    <= '0;
            r2_q    <= '0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    assign bus.rdy       = (state_q == S_IDLE);
    assign bus.done      = done_q;
    assign bus.count     = r2_q;
    // start is combinational into load_regs, so mask it while reset is held.
    assign bus.load_regs = load_regs && !rst;
    assign bus.shift     = shift;
    assign bus.incr_r2   = incr_r2;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_ones_counter_oh.sv
// Randomized self-checking bench for ones_counter_oh with a bit-scan reference model.
module tb_ones_counter_oh;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ones_counter_oh_if #(.WIDTH(WIDTH)) bus ();
    ones_counter_oh #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic abort_in;
`ifdef ONES_CNT_ABORT_EN
    assign abort_in = bus.abort;
`else
    assign abort_in = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one entry per busy cycle (state shown, count shown, increment strobe)
    typedef struct packed {
        logic [3:0] st;
        logic [7:0] cnt;
        logic       inc;
    } item_t;

    item_t q[$];
    bit    m_busy = 1'b0;
    bit    m_done = 1'b0;
    int    m_cnt  = 0;
    int    m_final = 0;

    function automatic void build(input logic [WIDTH-1:0] v);
        item_t it;
        int    cur;
        int    top;
        q.delete();
        cur = 0;
        top = -1;
        for (int i = 0; i < WIDTH; i++) if (v[i]) top = i;
        it.st = 4'b0010; it.cnt = 8'(cur); it.inc = 1'b0; q.push_back(it);
        for (int i = 0; i <= top; i++) begin
            it.st = 4'b0100; it.cnt = 8'(cur); it.inc = 1'b0;   q.push_back(it);
            it.st = 4'b1000; it.cnt = 8'(cur); it.inc = v[i];   q.push_back(it);
            if (v[i]) begin
                cur++;
                it.st = 4'b0010; it.cnt = 8'(cur); it.inc = 1'b0; q.push_back(it);
            end
        end
        m_final = cur;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (bus.start) begin
                build(bus.data_in);
                m_busy = 1'b1;
            end
        end else if (abort_in) begin
            m_cnt  = (q.size() > 1) ? int'(q[1].cnt) : m_final;
            q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_cnt  = m_final;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] est;
        int         ecnt;
        bit         einc;
        est  = (m_busy && q.size() > 0) ? q[0].st : 4'b0001;
        ecnt = (m_busy && q.size() > 0) ? int'(q[0].cnt) : m_cnt;
        einc = (m_busy && q.size() > 0) ? q[0].inc : 1'b0;
        check("state",     64'(bus.state),     64'(est));
        check("rdy",       64'(bus.rdy),       64'(!m_busy));
        check("done",      64'(bus.done),      64'(m_done));
        check("count",     64'(bus.count),     64'(ecnt));
        check("load_regs", 64'(bus.load_regs), 64'(!m_busy && bus.start && !rst));
        check("shift",     64'(bus.shift),     64'(est == 4'b0100));
        check("incr_r2",   64'(bus.incr_r2),   64'(einc));
    end

    task automatic drive(input bit s, input logic [WIDTH-1:0] d);
        @(posedge clk); #2;
        bus.start   = s;
        bus.data_in = d;
    endtask

    // One start pulse, then count busy cycles up to done; returns busy count and state trace
    task automatic run_op(input logic [WIDTH-1:0] v, output int n, output logic [3:0] trace [0:31]);
        drive(1'b1, v);
        @(posedge clk); #2;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 200) begin
            if (n < 32) trace[n] = bus.state;
            n++;
            @(posedge clk); #2;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int         n;
        logic [3:0] trace [0:31];
        logic [3:0] exp05 [0:8];
        exp05 = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0010};

        bus.start   = 1'b0;
        bus.data_in = '0;
`ifdef ONES_CNT_ABORT_EN
        bus.abort   = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_state", 64'(bus.state), 64'h1);
        check("reset_count", 64'(bus.count), 64'h0);
        check("reset_rdy",   64'(bus.rdy),   64'h1);
        rst = 1'b0;

        run_op(8'h05, n, trace);
        check("lat_05",   64'(n),         64'd9);
        check("count_05", 64'(bus.count), 64'd2);
        for (int i = 0; i < 9; i++) check("trace_05", 64'(trace[i]), 64'(exp05[i]));

        run_op(8'h00, n, trace);
        check("lat_00",   64'(n),         64'd1);
        check("count_00", 64'(bus.count), 64'd0);
        check("rdy_00",   64'(bus.rdy),   64'd1);

        run_op(8'hFF, n, trace);
        check("lat_FF",   64'(n),         64'd25);
        check("count_FF", 64'(bus.count), 64'd8);

        run_op(8'h80, n, trace);
        check("lat_80",   64'(n),         64'd18);
        check("count_80", 64'(bus.count), 64'd1);

        // start held high, data changed mid-run, re-accepted in the done cycle
        drive(1'b1, 8'h0F);
        @(posedge clk); #2;
        n = 0;
        while (!bus.done && n < 200) begin
            if (n == 3) bus.data_in = 8'hFF;
            n++;
            @(posedge clk); #2;
        end
        check("lat_held",   64'(n),             64'd13);
        check("count_held", 64'(bus.count),     64'd4);
        check("b2b_load",   64'(bus.load_regs), 64'd1);
        @(posedge clk); #2;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 200) begin n++; @(posedge clk); #2; end
        check("count_b2b", 64'(bus.count), 64'd8);

        // asynchronous reset mid-run
        drive(1'b1, 8'hFF);
        @(posedge clk); #2;
        bus.start = 1'b0;
        n = 0;
        while (!(bus.state == 4'b0100 && bus.count != '0) && n < 200) begin n++; @(posedge clk); #2; end
        rst = 1'b1;
        #1;
        check("arst_state", 64'(bus.state), 64'h1);
        check("arst_count", 64'(bus.count), 64'h0);
        check("arst_done",  64'(bus.done),  64'h0);
        rst = 1'b0;
        run_op(8'h05, n, trace);
        check("post_rst_count", 64'(bus.count), 64'd2);

`ifdef ONES_CNT_ABORT_EN
        drive(1'b1, 8'hFF);
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #2; end
        bus.abort = 1'b1;
        @(posedge clk); #2;
        bus.abort = 1'b0;
        check("abort_state", 64'(bus.state), 64'h1);
        check("abort_done",  64'(bus.done),  64'h0);
        check("abort_count", 64'(bus.count), 64'd2);
        repeat (3) @(posedge clk);
        #2;
        check("abort_hold", 64'(bus.count), 64'd2);
        bus.abort = 1'b1;
        drive(1'b1, 8'h03);
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n = 0;
        while (!bus.done && n < 200) begin n++; @(posedge clk); #2; end
        check("abort_idle_start", 64'(bus.count), 64'd2);
`endif

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            logic [WIDTH-1:0] d;
            case ($urandom_range(0, 3))
                0: d = 8'h00;
                1: d = 8'hFF;
                2: d = 8'(1 << $urandom_range(0, WIDTH - 1));
                default: d = 8'($urandom);
            endcase
            drive(($urandom_range(0, 3) == 0), d);
`ifdef ONES_CNT_ABORT_EN
            bus.abort = ($urandom_range(0, 15) == 0);
`endif
        end
        drive(1'b0, '0);
`ifdef ONES_CNT_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (40) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ones_counter_oh.md
ONES_COUNTER_OH -- requirements
Module: ones_counter_oh

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1), count width; not overridden.
REQ-003 clk  input  1  rising-edge clock; one clock for the block.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to count the ones in data_in.
REQ-006 data_in  input  WIDTH  operand, sampled only when a start is accepted.
REQ-007 abort  input  1  cancel the operation in progress; present only with ONES_CNT_ABORT_EN.
REQ-008 rdy  output  1  high in S_idle only.
REQ-009 done  output  1  one-cycle pulse, high when the result is valid.
REQ-010 count  output  CW  number of ones; the final value is held until the next accepted start.
REQ-011 load_regs, shift, incr_r2  output  1 each  datapath strobes, decoded from the state.
REQ-012 state  output  4  one-hot state vector {S_3,S_2,S_1,S_idle}.

Function
REQ-013 Controller SHALL be one-hot with four states: S_idle=0001, S_1=0010, S_2=0100, S_3=1000.
REQ-014 Datapath registers: R1 (WIDTH), R2 (CW, drives count) and E (1 bit).
REQ-015 S_idle: rdy=1; if start=1, load_regs=1, R1<=data_in, R2<=0, E<=0, next state S_1; otherwise stay in S_idle.
REQ-016 S_1: if R1==0, next state S_idle and done<=1 (registered, so done is high in the first S_idle cycle); otherwise next state S_2.
REQ-017 S_2: shift=1, R1<=R1>>1 with MSB filled with 0, E<=R1[0], next state S_3.
REQ-018 S_3: if E=1, incr_r2=1, R2<=R2+1, next state S_1; if E=0, next state S_2.
REQ-019 Latency from the start-accept edge to the done cycle SHALL be 1+2(m+1)+k cycles, where m = index of the highest set bit and k = number of ones; for data_in=0 it SHALL be 1 cycle plus the done cycle.
REQ-020 start outside S_idle SHALL be ignored, with no effect on R1, R2 or state.
REQ-021 start in the done cycle SHALL be accepted, since that cycle is S_idle; done and load_regs are then both high in the same cycle.
REQ-022 R2 SHALL never wrap: its maximum value is WIDTH, which fits in CW bits.
REQ-023 Any non-one-hot or all-zero state vector SHALL return to S_idle on the next clock edge, with done=0.
REQ-024 Strobes load_regs, shift and incr_r2 SHALL be mutually exclusive and high for at most one cycle per state visit.

Reset
REQ-025 While rst=1: state=0001, R1=0, R2=0, E=0, done=0, so rdy=1, count=0 and all strobes are 0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation immediately (asynchronously); no done pulse is issued.
REQ-027 After rst is released, the block SHALL accept a start on the first rising clock edge.

Configuration
REQ-028 Macro ONES_CNT_ABORT_EN defined: the abort port exists.
  - abort=1 in S_1, S_2 or S_3 moves the block to S_idle on the next edge.
  - done stays 0; count holds the partial R2.
  - abort has priority over all other transitions.
  - abort in S_idle has no effect; abort and start together in S_idle: start wins.
REQ-029 Macro undefined: no abort port; behaviour is exactly REQ-013..REQ-024.

Verification
REQ-030 WIDTH=8, data_in=8'h05, start pulse -> state sequence S_1,S_2,S_3,S_1,S_2,S_3,S_2,S_3,S_1 (9 cycles), then done=1 with count=2.
REQ-031 WIDTH=8, data_in=8'h00 -> one S_1 cycle, then done=1, count=0, rdy=1.
REQ-032 WIDTH=8, data_in=8'hFF -> done 25 cycles after accept with count=8; repeat with data_in=8'h80 -> 18 cycles, count=1.
REQ-033 start held high throughout an operation, new data_in asserted mid-run -> result unaffected; back-to-back start in the done cycle is accepted (load_regs=1 alongside done=1).
REQ-034 rst pulsed in S_2 mid-run -> state=0001, count=0, done=0 without waiting for a clock edge; next start counts correctly.
REQ-035 With ONES_CNT_ABORT_EN: data_in=8'hFF, abort in the 6th busy cycle -> S_idle next cycle, no done pulse, count=2 held.
